// File: rtl/cache_plru_replace.sv
// ---------------------------------------------------------------------------
// cache_plru_replace
//
// Per-set tree pseudo-LRU replacement controller. It sits beside the tag
// array, and each operation takes two cycles:
//   - Cycle 0: the set is read. A fill request wins over an access request.
//   - Cycle 1: the victim is chosen (an invalid way first, otherwise a walk
//     of the tree) and the path to the used way is marked MRU.
// A one-deep bypass forwards a cycle-1 write to a cycle-0 read of the same
// set. Back-to-back operations on one set therefore behave like serial
// execution.
//
// Flag storage is heap indexed. Node 1 is the root, and the children of
// node n are 2n and 2n+1. A flag of 0 means the LRU side is on the left.
// Bit 0 of each flag vector is unused and held at 0.
//
// Optional feature, selected by the macro CACHE_PLRU_WAY_LOCK_EN:
//   - Locked ways are avoided by both the tree walk and the invalid-way
//     search.
//   - If every way is locked, the locks are ignored.
//   - Without the macro, lock_mask is ignored.
//
// Ports
//   clk                clock
//   reset              asynchronous active-high reset
//   fill_en            cycle 0: request a victim for fill_set
//   fill_set           set being filled
//   fill_valid         cycle 1: per-way valid bits from the tag array
//   fill_way           cycle 1: selected victim way
//   fill_way_valid     cycle 1: fill_way is meaningful
//   access_en          cycle 0: lookup in access_set
//   access_set         set being accessed
//   access_update_en   cycle 1: hit, promote access_update_way to MRU
//   access_update_way  way that hit
//   lock_mask          per-way lock (used only with CACHE_PLRU_WAY_LOCK_EN)
// ---------------------------------------------------------------------------
module cache_plru_replace #(
  parameter int NUM_SETS        = 64,
  parameter int NUM_WAYS        = 4,
  parameter int SET_INDEX_WIDTH = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  parameter int WAY_INDEX_WIDTH = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       fill_en,
  input  logic [SET_INDEX_WIDTH-1:0] fill_set,
  input  logic [NUM_WAYS-1:0]        fill_valid,
  output logic [WAY_INDEX_WIDTH-1:0] fill_way,
  output logic                       fill_way_valid,
  input  logic                       access_en,
  input  logic [SET_INDEX_WIDTH-1:0] access_set,
  input  logic                       access_update_en,
  input  logic [WAY_INDEX_WIDTH-1:0] access_update_way,
  input  logic [NUM_WAYS-1:0]        lock_mask
);

  localparam int LEVELS = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 0;
  localparam logic [SET_INDEX_WIDTH:0] SET_LIMIT = (SET_INDEX_WIDTH+1)'(NUM_SETS);
  localparam logic [WAY_INDEX_WIDTH:0] WAY_LIMIT = (WAY_INDEX_WIDTH+1)'(NUM_WAYS);

  typedef logic [NUM_WAYS-1:0] flags_t;

  flags_t flag_mem [NUM_SETS];

  // Stage-1 registers
  logic [SET_INDEX_WIDTH-1:0] s1_set;
  logic                       s1_fill;
  logic                       s1_access;
  flags_t                     s1_flags;

  // Cycle-0 read path
  logic [SET_INDEX_WIDTH-1:0] rd_set;
  logic                       rd_in_range;
  flags_t                     rd_flags;

  // Cycle-1 decide/update path
  logic                       s1_in_range;
  logic [WAY_INDEX_WIDTH-1:0] walk_way;
  logic [WAY_INDEX_WIDTH-1:0] inv_way;
  logic                       inv_found;
  logic [WAY_INDEX_WIDTH-1:0] victim;
  logic [WAY_INDEX_WIDTH-1:0] upd_way;
  logic                       upd_en;
  logic                       wr_en;
  flags_t                     new_flags;

  // eff_sub[n] is 1 when the walk must not descend into heap node n.
  // Leaves sit at NUM_WAYS + way.
  logic [2*NUM_WAYS-1:0]      eff_sub;
  logic [NUM_WAYS-1:0]        eff_lock;

`ifdef CACHE_PLRU_WAY_LOCK_EN
  logic [2*NUM_WAYS-1:0]      sub_locked;

  always_comb begin
    sub_locked = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      sub_locked[NUM_WAYS + w] = lock_mask[w];
    end
    for (int n = NUM_WAYS - 1; n >= 1; n--) begin
      sub_locked[n] = sub_locked[2*n] & sub_locked[2*n + 1];
    end
    // The root is fully locked when every way is locked; fall back to pure PLRU.
    if (sub_locked[1]) begin
      eff_sub  = '0;
      eff_lock = '0;
    end else begin
      eff_sub  = sub_locked;
      eff_lock = lock_mask;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^lock_mask;
  assign eff_sub     = '0;
  assign eff_lock    = '0;
`endif

  // Cycle 0: select the set and read it, forwarding an update that is
  // being written to the same set this cycle.
  always_comb begin
    rd_set      = fill_en ? fill_set : access_set;
    rd_in_range = ({1'b0, rd_set} < SET_LIMIT);
    rd_flags    = '0;
    if (rd_in_range) begin
      rd_flags = flag_mem[rd_set];
    end
    if (wr_en && (s1_set == rd_set)) begin
      rd_flags = new_flags;
    end
  end

  // Cycle 1: tree walk, with a detour around fully locked subtrees.
  always_comb begin
    int node;
    int child;
    node = 1;
    for (int l = 0; l < LEVELS; l++) begin
      child = 2*node + int'(s1_flags[node]);
      if (eff_sub[child]) begin
        child = child ^ 1;
      end
      node = child;
    end
    walk_way = WAY_INDEX_WIDTH'(node - NUM_WAYS);
  end

  // Cycle 1: find the lowest-index invalid way that is not locked.
  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!fill_valid[w] && !eff_lock[w]) begin
        inv_found = 1'b1;
        inv_way   = WAY_INDEX_WIDTH'(w);
      end
    end
  end

  assign victim = inv_found ? inv_way : walk_way;

  // Cycle 1: mark the used way MRU. Each flag on its path points to the
  // sibling side.
  always_comb begin
    int pidx;
    upd_way   = s1_fill ? victim : access_update_way;
    upd_en    = s1_fill | access_update_en;
    new_flags = s1_flags;
    pidx      = NUM_WAYS + int'(upd_way);
    for (int l = 0; l < LEVELS; l++) begin
      // A left child (even index) sends the LRU side to the right (1).
      new_flags[pidx / 2] = ((pidx % 2) == 0);
      pidx = pidx / 2;
    end
    new_flags[0] = 1'b0;
  end

  assign s1_in_range = ({1'b0, s1_set} < SET_LIMIT);
  assign wr_en       = upd_en & s1_in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_set    <= '0;
      s1_fill   <= 1'b0;
      s1_access <= 1'b0;
      s1_flags  <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        flag_mem[s] <= '0;
      end
    end else begin
      s1_set    <= rd_set;
      s1_fill   <= fill_en;
      s1_access <= access_en;
      s1_flags  <= rd_flags;
      if (wr_en) begin
        flag_mem[s1_set] <= new_flags;
      end
    end
  end

  assign fill_way_valid = s1_fill;
  assign fill_way       = s1_fill ? victim : '0;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!reset && access_update_en) begin
      assert (s1_access)
        else $error("access_update_en without access_en in the previous cycle");
      assert ({1'b0, access_update_way} < WAY_LIMIT)
        else $error("access_update_way out of range");
    end
  end
`endif

endmodule

// File: tb/tb_cache_plru_replace.sv
module tb_cache_plru_replace;

  logic        clk;
  logic        reset;

  // 4-way, 64-set instance
  logic        fill_en;
  logic [5:0]  fill_set;
  logic [3:0]  fill_valid;
  logic [1:0]  fill_way;
  logic        fill_way_valid;
  logic        access_en;
  logic [5:0]  access_set;
  logic        access_update_en;
  logic [1:0]  access_update_way;
  logic [3:0]  lock_mask;

  // 32-way, 4-set instance
  logic        w_fill_en;
  logic [1:0]  w_fill_set;
  logic [31:0] w_fill_valid;
  logic [4:0]  w_fill_way;
  logic        w_fill_way_valid;
  logic        w_access_en;
  logic [1:0]  w_access_set;
  logic        w_access_update_en;
  logic [4:0]  w_access_update_way;
  logic [31:0] w_lock_mask;

  int errors;
  int checks;
  int exp1 [4];
  logic [31:0] seen;

  cache_plru_replace #(.NUM_SETS(64), .NUM_WAYS(4)) dut (
    .clk(clk), .reset(reset),
    .fill_en(fill_en), .fill_set(fill_set), .fill_valid(fill_valid),
    .fill_way(fill_way), .fill_way_valid(fill_way_valid),
    .access_en(access_en), .access_set(access_set),
    .access_update_en(access_update_en), .access_update_way(access_update_way),
    .lock_mask(lock_mask)
  );

  cache_plru_replace #(.NUM_SETS(4), .NUM_WAYS(32)) dut32 (
    .clk(clk), .reset(reset),
    .fill_en(w_fill_en), .fill_set(w_fill_set), .fill_valid(w_fill_valid),
    .fill_way(w_fill_way), .fill_way_valid(w_fill_way_valid),
    .access_en(w_access_en), .access_set(w_access_set),
    .access_update_en(w_access_update_en), .access_update_way(w_access_update_way),
    .lock_mask(w_lock_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
  endtask

  function automatic logic [4:0] bitrev5(input int v);
    logic [4:0] r;
    logic [31:0] vv;
    vv = v;
    for (int b = 0; b < 5; b++) r[4-b] = vv[b];
    return r;
  endfunction

  task automatic idle();
    fill_en = 0; fill_set = '0; fill_valid = 4'hF;
    access_en = 0; access_set = '0; access_update_en = 0; access_update_way = '0;
    lock_mask = '0;
    w_fill_en = 0; w_fill_set = '0; w_fill_valid = '1;
    w_access_en = 0; w_access_set = '0; w_access_update_en = 0; w_access_update_way = '0;
    w_lock_mask = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    reset = 1;
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    exp1 = '{0, 2, 1, 3};
    idle();
    reset = 1;
    #1;
    check("reset_valid", fill_way_valid, 0);
    check("reset_way", fill_way, 0);
    check("reset_valid32", w_fill_way_valid, 0);
    @(negedge clk);
    reset = 0;

    // Four back-to-back fills on set 3
    apply_reset();
    fill_en = 1; fill_set = 6'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      fill_valid = 4'hF;
      fill_en = (i < 3);
      #1;
      check("t1_valid", fill_way_valid, 1);
      check("t1_way", fill_way, exp1[i]);
    end
    @(negedge clk); idle();
    #1 check("t1_idle_valid", fill_way_valid, 0);

    // Invalid-way preference, then a plain walk
    apply_reset();
    fill_en = 1; fill_set = 6'd7;
    @(negedge clk);
    fill_en = 0; fill_valid = 4'b1011;
    #1 check("t2_invalid_way", fill_way, 2);
    @(negedge clk);
    fill_en = 1; fill_set = 6'd7; fill_valid = 4'hF;
    @(negedge clk);
    fill_en = 0;
    #1 check("t2_walk_way", fill_way, 0);
    @(negedge clk); idle();

    // Hit on way 0, then an immediate fill on the same set
    apply_reset();
    access_en = 1; access_set = 6'd9;
    @(negedge clk);
    access_en = 0; access_update_en = 1; access_update_way = 2'd0;
    fill_en = 1; fill_set = 6'd9;
    #1 check("t3_access_no_valid", fill_way_valid, 0);
    @(negedge clk);
    access_update_en = 0; fill_en = 0; fill_valid = 4'hF;
    #1;
    check("t3_fill_valid", fill_way_valid, 1);
    check("t3_fill_way", fill_way, 2);
    @(negedge clk); idle();

    // Fill and access together: the fill owns the update slot
    apply_reset();
    fill_en = 1; fill_set = 6'd12; access_en = 1; access_set = 6'd12;
    @(negedge clk);
    fill_en = 0; access_en = 0; access_update_en = 1; access_update_way = 2'd3;
    fill_valid = 4'hF;
    #1;
    check("t4_first_valid", fill_way_valid, 1);
    check("t4_first_way", fill_way, 0);
    @(negedge clk);
    access_update_en = 0; fill_en = 1; fill_set = 6'd12;
    @(negedge clk);
    fill_en = 0;
    #1 check("t4_second_way", fill_way, 2);
    @(negedge clk);
    fill_en = 1; fill_set = 6'd13;
    @(negedge clk);
    fill_en = 0;
    #1 check("t4_other_set_way", fill_way, 0);
    @(negedge clk); idle();

`ifdef CACHE_PLRU_WAY_LOCK_EN
    apply_reset();
    fill_en = 1; fill_set = 6'd0; lock_mask = 4'b0001;
    @(negedge clk);
    fill_en = 0;
    #1 check("lock_one_way", fill_way, 1);
    apply_reset();
    fill_en = 1; fill_set = 6'd0; lock_mask = 4'b1111;
    @(negedge clk);
    fill_en = 0;
    #1 check("lock_all_way", fill_way, 0);
    @(negedge clk); idle();
`endif

    // 32 ways: back-to-back fills visit every way in bit-reversed order
    apply_reset();
    seen = '0;
    w_fill_en = 1; w_fill_set = 2'd1;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      w_fill_en = (i < 31);
      #1;
      check("w32_way", w_fill_way, bitrev5(i));
      seen[w_fill_way] = 1'b1;
    end
    check("w32_all_seen", seen, 32'hFFFF_FFFF);

    // Reset while a fill is in cycle 1: no write, and all flags clear
    @(negedge clk);
    w_fill_en = 1;
    @(negedge clk);
    w_fill_en = 1;
    #1 check("w32_pre_way", w_fill_way, 0);
    @(negedge clk);
    w_fill_en = 0; reset = 1;
    #1 check("w32_reset_valid", w_fill_way_valid, 0);
    @(negedge clk);
    reset = 0; w_fill_en = 1; w_fill_set = 2'd1;
    @(negedge clk);
    w_fill_en = 1;
    #1 check("w32_post_way0", w_fill_way, 0);
    @(negedge clk);
    w_fill_en = 0;
    #1 check("w32_post_way1", w_fill_way, 16);
    @(negedge clk); idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
